// File: rtl/mux_lut_gate_unit.sv
// WIDTH-lane registered gate unit: each lane applies a 4-entry truth table picked by op.
// Optional lane reductions (red_and/red_or/red_xor) are built when LANE_REDUCE_EN is defined.
module mux_lut_gate_unit #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CNT_W    = 16,
  parameter logic [3:0]  LUT_INIT = 4'b0110
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_lut,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] op_count
`ifdef LANE_REDUCE_EN
  ,
  output logic             red_and,
  output logic             red_or,
  output logic             red_xor
`endif
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_LUT  = 3'd7
  } op_e;

  // Truth tables, bit index = {a,b}.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;
  localparam logic [3:0] TT_NOTA = 4'b0011;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [3:0]       lut_q;
  logic [3:0]       truth_tbl;
  logic [WIDTH-1:0] y_next;
  logic             accept;

  // Single-entry stage: a slot frees up as soon as the consumer takes it.
  always_comb begin
    in_ready = !out_valid || out_ready;
    accept   = in_valid && in_ready;
  end

  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
    truth_tbl = TT_AND;
    case (op_e'(op))
      OP_AND:  truth_tbl = TT_AND;
      OP_OR:   truth_tbl = TT_OR;
      OP_NAND: truth_tbl = TT_NAND;
      OP_NOR:  truth_tbl = TT_NOR;
      OP_XOR:  truth_tbl = TT_XOR;
      OP_XNOR: truth_tbl = TT_XNOR;
      OP_NOTA: truth_tbl = TT_NOTA;
      OP_LUT:  truth_tbl = lut_q;
    endcase
  end

  // Per-lane 4:1 mux over the selected table.
  always_comb begin
    y_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      y_next[i] = truth_tbl[{a[i], b[i]}];
    end
  end

  // An op 7 accepted in the same cycle as cfg_we sees the old lut_q.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      lut_q <= LUT_INIT;
    end else if (cfg_we) begin
      lut_q <= cfg_lut;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      y         <= y_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (accept && (op_count != CNT_MAX)) begin
      op_count <= op_count + 1'b1;
    end
  end

`ifdef LANE_REDUCE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      red_and <= 1'b0;
      red_or  <= 1'b0;
      red_xor <= 1'b0;
    end else if (accept) begin
      red_and <= &y_next;
      red_or  <= |y_next;
      red_xor <= ^y_next;
    end
  end
`endif

endmodule
